spmc_spi_slave: RTL and testbench
=================================

Name: spmc_spi_slave

Overview:
SPI slave peripheral for the SpartanMC peripheral bus, the responder counterpart of the SD-card SPI master. An external SPI master (another FPGA, MCU or test host) clocks bytes in and out. The CPU exchanges them through a 64-word peripheral window: a data register, a status register and a control register. SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames. All SPI pins are oversampled in the clk_peri domain.

Parameters:
BASE_ADR, 10'h0, peripheral base address; must be divisible by 64; decoded from addr_peri[9:6]
DEFAULT_TX, 8'hFF, byte shifted out when the CPU has not loaded TX_BUF before a frame starts

Ports:
clk_peri  input  1  system clock; must be >= 8x the SPI SCLK frequency
reset  input  1  asynchronous active-low reset
do_peri  input  18  data bus from the CPU
di_peri  output  18  data bus to the CPU; {10'b0, rdata} while selected and reading, else 18'b0
addr_peri  input  10  address bus from the CPU
access_peri  input  1  peripheral access strobe; high for exactly one cycle per access
wr_peri  input  1  write enable
spi_sclk  input  1  SPI clock from the master
spi_cs_n  input  1  chip select from the master, active low
spi_mosi  input  1  master-out data
spi_miso  output  1  slave-out data
spi_miso_oe  output  1  tristate enable for spi_miso; high only while selected and EN=1
irq  output  1  only present with SPI_SLAVE_IRQ_EN

Behaviour:
- Bus decode: select = access_peri & (addr_peri[9:6] == BASE_ADR[9:6]). Register index is addr_peri[1:0]; indices 3 and above read 0 and ignore writes. Reads are combinational.
- Register 0, DATA:
  - Read returns RX_BUF and clears RX_VALID in the access cycle.
  - Write loads TX_BUF from do_peri[7:0] and sets TX_FULL.
- Register 1, STATUS (read-only fields):
  - bit0 RX_VALID, bit1 TX_FULL, bit2 OVERRUN, bit3 CS_ACTIVE, bit4 ABORT.
  - Writing 1 to bit2 or bit4 clears that bit (W1C); all other bits ignore writes.
- Register 2, CTRL: bit0 EN, bit1 IRQ_EN. Reads back written value.
- Reset values: all registers 0; TX_BUF=8'h00; shift register 0; bit counter 0; spi_miso=0; spi_miso_oe=0; di_peri=0; irq=0.
- Input synchronisation:
  - spi_sclk, spi_cs_n and spi_mosi each pass a 2-FF synchroniser, then a third stage for edge detection.
  - An SCLK or CS edge is acted on 3 clk_peri cycles after the pin change.
- State machine: IDLE, SHIFT.
  - IDLE -> SHIFT on a synchronised CS falling edge while EN=1.
    - Load the shift register with TX_BUF if TX_FULL, else DEFAULT_TX; clear TX_FULL.
    - Set bit counter to 0 and drive spi_miso = shift[7].
  - SHIFT, SCLK rising: shift in the synchronised mosi at the LSB; counter += 1.
  - SHIFT, after the 8th rising edge (counter wraps 7 -> 0):
    - RX_BUF <= received byte and RX_VALID <= 1.
    - If RX_VALID was already 1 and is not being cleared this cycle, set OVERRUN; the new byte overwrites RX_BUF.
  - SHIFT, SCLK falling:
    - If counter != 0, spi_miso <= next bit.
    - If counter == 0 (byte boundary), reload the shift register from TX_BUF/DEFAULT_TX exactly as at frame start.
  - SHIFT -> IDLE on CS rising edge. If counter != 0, the partial byte is discarded and ABORT is set. The counter resets.
  - EN cleared while in SHIFT: return to IDLE immediately; no ABORT.
- CS_ACTIVE = state == SHIFT. spi_miso_oe = CS_ACTIVE.
- Simultaneous events:
  - CPU DATA read in the same cycle a byte completes: RX_VALID stays 1 with the new byte; no OVERRUN.
  - CPU DATA write in the same cycle TX_BUF is consumed: the written byte is kept for the next frame and TX_FULL ends 1.
  - W1C of OVERRUN in the same cycle a new overrun occurs: OVERRUN ends 1.
- Reset asserted mid-frame: all state returns to reset values immediately; the frame is lost with no flag.

Optional Feature:
Macro: SPI_SLAVE_IRQ_EN.
- Defined:
  - irq port exists.
  - irq is registered: irq <= IRQ_EN & (RX_VALID | OVERRUN | ABORT).
  - It deasserts the cycle after the CPU clears the causes.
- Not defined:
  - no irq port.
  - CTRL bit1 reads 0 and ignores writes.

Test Plan:
- CTRL=1, CPU writes DATA=8'hA5. Master sends 8'h3C in mode 0 at clk_peri/16 -> master receives 8'hA5; STATUS=8'h01; DATA reads 8'h3C; STATUS then 8'h00.
- EN=1 with no TX write. Master sends 2 bytes 8'h11, 8'h22 in one CS frame without reading -> master receives 8'hFF, 8'hFF; DATA reads 8'h22; STATUS bit2=1; write STATUS=8'h04 clears it.
- Master drops CS after 5 SCLK edges -> RX_VALID=0, STATUS bit4=1, and the next full frame receives correctly.
- The DATA read cycle coincides with 8th-bit completion -> RX_VALID=1 holding the new byte, OVERRUN=0.
- EN=0, master sends a frame -> spi_miso_oe stays 0, STATUS unchanged. Assert reset low mid-frame -> all registers and outputs read 0 immediately.
- With SPI_SLAVE_IRQ_EN and CTRL=3, receive one byte -> irq=1 within 5 clk_peri cycles of the 8th rising SCLK; irq=0 one cycle after the DATA read.

Source files
------------

// File: rtl/spmc_spi_slave.sv
// SPI mode-0 slave (MSB first, 8-bit frames) on the SpartanMC peripheral bus.
// Define SPI_SLAVE_IRQ_EN to add the registered irq output and CTRL.IRQ_EN.
module spmc_spi_slave #(
   parameter logic [9:0] BASE_ADR   = 10'h0,
   parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
   input  logic        clk_peri,
   input  logic        reset,
   input  logic [17:0] do_peri,
   output logic [17:0] di_peri,
   input  logic [9:0]  addr_peri,
   input  logic        access_peri,
   input  logic        wr_peri,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int unsigned BUS_W  = 18;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned SYNC_W = 3;
   localparam int unsigned CTRL_W = 2;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_W-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_W-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_W-1:0] mosi_sync_q, mosi_sync_d;

   logic [BYTE_W-1:0] shift_q,  shift_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              miso_q,   miso_d;
   logic [BYTE_W-1:0] rx_buf_q, rx_buf_d;
   logic              rx_valid_q, rx_valid_d;
   logic [BYTE_W-1:0] tx_buf_q, tx_buf_d;
   logic              tx_full_q, tx_full_d;
   logic              overrun_q, overrun_d;
   logic              abort_q,   abort_d;
   logic [CTRL_W-1:0] ctrl_q,    ctrl_d;

   logic              sel_c, rd_data_c, wr_data_c, wr_status_c, wr_ctrl_c;
   logic [1:0]        idx_c;
   logic [BYTE_W-1:0] rdata_c;
   logic [BYTE_W-1:0] tx_next_c;
   logic [BYTE_W-1:0] rx_byte_c;
   logic              sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;
   logic              en_c, cs_active_c;
   logic              start_c, byte_done_c, abort_set_c, consume_c;
   logic              unused_bits;

   // Bus decode and combinational read mux
   assign sel_c       = access_peri & (addr_peri[9:6] == BASE_ADR[9:6]);
   assign idx_c       = addr_peri[1:0];
   assign rd_data_c   = sel_c & ~wr_peri & (idx_c == 2'd0);
   assign wr_data_c   = sel_c &  wr_peri & (idx_c == 2'd0);
   assign wr_status_c = sel_c &  wr_peri & (idx_c == 2'd1);
   assign wr_ctrl_c   = sel_c &  wr_peri & (idx_c == 2'd2);
   assign unused_bits = ^{do_peri[17:8], do_peri[3], addr_peri[5:2]};

   assign cs_active_c = (state_q == S_SHIFT);
   assign en_c        = ctrl_q[0];

   always_comb begin
      rdata_c = '0;
      case (idx_c)
         2'd0:    rdata_c = rx_buf_q;
         2'd1:    rdata_c = {3'b000, abort_q, cs_active_c, overrun_q, tx_full_q, rx_valid_q};
         2'd2:    rdata_c = BYTE_W'(ctrl_q);
         default: rdata_c = '0;
      endcase
   end

   assign di_peri = (sel_c && !wr_peri) ? BUS_W'(rdata_c) : '0;

   // Pin synchronisers: two stages for metastability, a third for edge detection
   assign sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
   assign cs_sync_d   = {cs_sync_q[1:0],   spi_cs_n};
   assign mosi_sync_d = {mosi_sync_q[1:0], spi_mosi};

   assign sclk_rise_c =  sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall_c = ~sclk_sync_q[1] &  sclk_sync_q[2];
   assign cs_fall_c   = ~cs_sync_q[1]   &  cs_sync_q[2];
   assign cs_rise_c   =  cs_sync_q[1]   & ~cs_sync_q[2];

   assign tx_next_c = tx_full_q ? tx_buf_q : DEFAULT_TX;
   // MOSI taken from the oldest stage: it settled half an SCLK period before the rising edge
   assign rx_byte_c = {shift_q[BYTE_W-2:0], mosi_sync_q[2]};

   // FSM state register
   always_ff @(posedge clk_peri or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cs_fall_c && en_c) state_d = S_SHIFT;
         S_SHIFT: if (!en_c || cs_rise_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign start_c = (state_q == S_IDLE) & cs_fall_c & en_c;

   // FSM outputs: shifter, bit counter and MISO
   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      miso_d      = miso_q;
      byte_done_c = 1'b0;
      abort_set_c = 1'b0;
      consume_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_c) begin
               shift_d   = tx_next_c;
               miso_d    = tx_next_c[BYTE_W-1];
               consume_c = 1'b1;
            end
         end
         S_SHIFT: begin
            if (!en_c) begin
               cnt_d  = '0;
               miso_d = 1'b0;
            end else if (cs_rise_c) begin
               cnt_d       = '0;
               miso_d      = 1'b0;
               abort_set_c = (cnt_q != '0);
            end else if (sclk_rise_c) begin
               shift_d     = rx_byte_c;
               cnt_d       = cnt_q + CNT_W'(1);
               byte_done_c = (cnt_q == CNT_W'(7));
            end else if (sclk_fall_c) begin
               if (cnt_q != '0) begin
                  miso_d = shift_q[BYTE_W-1];
               end else begin
                  shift_d   = tx_next_c;
                  miso_d    = tx_next_c[BYTE_W-1];
                  consume_c = 1'b1;
               end
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Register file: setting events win over same-cycle CPU clears
   always_comb begin
      rx_buf_d   = rx_buf_q;
      rx_valid_d = rx_valid_q;
      tx_buf_d   = tx_buf_q;
      tx_full_d  = tx_full_q;
      overrun_d  = overrun_q;
      abort_d    = abort_q;
      ctrl_d     = ctrl_q;

      if (rd_data_c) rx_valid_d = 1'b0;
      if (byte_done_c) begin
         rx_buf_d   = rx_byte_c;
         rx_valid_d = 1'b1;
      end

      if (wr_status_c && do_peri[2]) overrun_d = 1'b0;
      if (byte_done_c && rx_valid_q && !rd_data_c) overrun_d = 1'b1;

      if (wr_status_c && do_peri[4]) abort_d = 1'b0;
      if (abort_set_c) abort_d = 1'b1;

      if (consume_c) tx_full_d = 1'b0;
      if (wr_data_c) begin
         tx_buf_d  = do_peri[BYTE_W-1:0];
         tx_full_d = 1'b1;
      end

      if (wr_ctrl_c) begin
`ifdef SPI_SLAVE_IRQ_EN
         ctrl_d = do_peri[CTRL_W-1:0];
`else
         ctrl_d = {1'b0, do_peri[0]};
`endif
      end
   end

   always_ff @(posedge clk_peri or negedge reset) begin
      if (!reset) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         miso_q      <= 1'b0;
         rx_buf_q    <= '0;
         rx_valid_q  <= 1'b0;
         tx_buf_q    <= '0;
         tx_full_q   <= 1'b0;
         overrun_q   <= 1'b0;
         abort_q     <= 1'b0;
         ctrl_q      <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         miso_q      <= miso_d;
         rx_buf_q    <= rx_buf_d;
         rx_valid_q  <= rx_valid_d;
         tx_buf_q    <= tx_buf_d;
         tx_full_q   <= tx_full_d;
         overrun_q   <= overrun_d;
         abort_q     <= abort_d;
         ctrl_q      <= ctrl_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = cs_active_c;

`ifdef SPI_SLAVE_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = ctrl_q[1] & (rx_valid_q | overrun_q | abort_q);

   always_ff @(posedge clk_peri or negedge reset) begin
      if (!reset) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spmc_spi_slave.sv
// Directed self-checking bench for spmc_spi_slave acting as a mode-0 SPI master at clk_peri/16.
module tb_spmc_spi_slave;

   localparam logic [9:0] BASE = 10'h080;

   logic        clk_peri = 1'b0;
   logic        reset = 1'b0;
   logic [17:0] do_peri = '0;
   logic [17:0] di_peri;
   logic [9:0]  addr_peri = '0;
   logic        access_peri = 1'b0;
   logic        wr_peri = 1'b0;
   logic        spi_sclk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
   logic        irq;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   spmc_spi_slave #(.BASE_ADR(BASE), .DEFAULT_TX(8'hFF)) dut (
      .clk_peri    (clk_peri),
      .reset       (reset),
      .do_peri     (do_peri),
      .di_peri     (di_peri),
      .addr_peri   (addr_peri),
      .access_peri (access_peri),
      .wr_peri     (wr_peri),
      .spi_sclk    (spi_sclk),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   always #5 clk_peri = ~clk_peri;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_wr(input logic [1:0] idx, input logic [7:0] data);
      @(negedge clk_peri);
      access_peri = 1'b1;
      wr_peri     = 1'b1;
      addr_peri   = {BASE[9:6], 4'b0000, idx};
      do_peri     = {10'b0, data};
      @(negedge clk_peri);
      access_peri = 1'b0;
      wr_peri     = 1'b0;
      do_peri     = '0;
   endtask

   task automatic cpu_rd_at(input logic [9:0] adr, output logic [17:0] d);
      @(negedge clk_peri);
      access_peri = 1'b1;
      wr_peri     = 1'b0;
      addr_peri   = adr;
      #1 d = di_peri;
      @(negedge clk_peri);
      access_peri = 1'b0;
      addr_peri   = '0;
   endtask

   task automatic cpu_rd(input logic [1:0] idx, output logic [17:0] d);
      cpu_rd_at({BASE[9:6], 4'b0000, idx}, d);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      spi_mosi = b;
      repeat (8) @(negedge clk_peri);
      spi_sclk = 1'b1;
      r = spi_miso;
      repeat (8) @(negedge clk_peri);
      spi_sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic cs_end();
      repeat (8) @(negedge clk_peri);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk_peri);
   endtask

   initial begin
      logic [17:0] d;
      logic [7:0]  rx;
      logic        r;

      repeat (3) @(negedge clk_peri);
      reset = 1'b1;
      repeat (2) @(negedge clk_peri);

      // Reset state
      cpu_rd(2'd1, d); check("reset_status", d, 18'h0);
      cpu_rd(2'd0, d); check("reset_data", d, 18'h0);
      cpu_rd(2'd2, d); check("reset_ctrl", d, 18'h0);
      check("reset_miso_oe", {17'b0, spi_miso_oe}, 18'h0);
      check("reset_miso", {17'b0, spi_miso}, 18'h0);

      // Register decode
      cpu_wr(2'd2, 8'h01);
      cpu_rd(2'd2, d); check("ctrl_readback", d, 18'h001);
      cpu_rd(2'd3, d); check("reg3_reads_zero", d, 18'h0);
      cpu_rd_at(10'h000, d); check("other_base_reads_zero", d, 18'h0);

      // Single byte with a loaded TX_BUF
      cpu_wr(2'd0, 8'hA5);
      cpu_rd(2'd1, d); check("tx_full_set", d, 18'h002);
      spi_cs_n = 1'b0;
      spi_byte(8'h3C, rx);
      cs_end();
      check("t1_master_rx", {10'b0, rx}, 18'h0A5);
      cpu_rd(2'd1, d); check("t1_status", d, 18'h001);
      cpu_rd(2'd0, d); check("t1_data", d, 18'h03C);
      cpu_rd(2'd1, d); check("t1_status_after_read", d, 18'h000);

      // Two bytes in one frame, no TX load, no read in between
      spi_cs_n = 1'b0;
      spi_byte(8'h11, rx);
      check("t2_master_rx0", {10'b0, rx}, 18'h0FF);
      spi_byte(8'h22, rx);
      check("t2_master_rx1", {10'b0, rx}, 18'h0FF);
      cs_end();
      cpu_rd(2'd1, d); check("t2_status_overrun", d, 18'h005);
      cpu_rd(2'd0, d); check("t2_data", d, 18'h022);
      cpu_rd(2'd1, d); check("t2_status_after_read", d, 18'h004);
      cpu_wr(2'd1, 8'h04);
      cpu_rd(2'd1, d); check("t2_overrun_w1c", d, 18'h000);

      // Aborted frame after 5 bits, then a clean frame
      spi_cs_n = 1'b0;
      for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
      repeat (4) @(negedge clk_peri);
      cpu_rd(2'd1, d); check("t3_cs_active", d, 18'h008);
      check("t3_miso_oe", {17'b0, spi_miso_oe}, 18'h001);
      cs_end();
      cpu_rd(2'd1, d); check("t3_abort", d, 18'h010);
      check("t3_miso_oe_idle", {17'b0, spi_miso_oe}, 18'h000);
      cpu_wr(2'd0, 8'h5A);
      spi_cs_n = 1'b0;
      spi_byte(8'hC3, rx);
      cs_end();
      check("t3_master_rx", {10'b0, rx}, 18'h05A);
      cpu_rd(2'd1, d); check("t3_status_after_frame", d, 18'h011);
      cpu_rd(2'd0, d); check("t3_data", d, 18'h0C3);
      cpu_wr(2'd1, 8'h10);
      cpu_rd(2'd1, d); check("t3_abort_w1c", d, 18'h000);

      // DATA read lands in the same cycle the second byte completes
      spi_cs_n = 1'b0;
      spi_byte(8'h81, rx);
      for (int i = 7; i >= 1; i--) spi_bit(1'(8'h7E >> i), r);
      spi_mosi = 1'b0;
      repeat (8) @(negedge clk_peri);
      spi_sclk = 1'b1;
      repeat (2) @(negedge clk_peri);
      access_peri = 1'b1;
      wr_peri     = 1'b0;
      addr_peri   = {BASE[9:6], 4'b0000, 2'd0};
      #1 d = di_peri;
      @(negedge clk_peri);
      access_peri = 1'b0;
      addr_peri   = '0;
      check("t4_read_old_byte", d, 18'h081);
      repeat (5) @(negedge clk_peri);
      spi_sclk = 1'b0;
      cs_end();
      cpu_rd(2'd1, d); check("t4_status_no_overrun", d, 18'h001);
      cpu_rd(2'd0, d); check("t4_data_new_byte", d, 18'h07E);

      // Disabled: frame is ignored
      cpu_wr(2'd2, 8'h00);
      spi_cs_n = 1'b0;
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      check("t5_miso_oe_disabled", {17'b0, spi_miso_oe}, 18'h000);
      cpu_rd(2'd1, d); check("t5_status_mid", d, 18'h000);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
      cs_end();
      cpu_rd(2'd1, d); check("t5_status_after", d, 18'h000);

      // Reset asserted mid-frame
      cpu_wr(2'd2, 8'h01);
      cpu_wr(2'd0, 8'h99);
      spi_cs_n = 1'b0;
      for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
      repeat (4) @(negedge clk_peri);
      check("t6_miso_oe_active", {17'b0, spi_miso_oe}, 18'h001);
      check("t6_miso_bit4", {17'b0, spi_miso}, 18'h001);
      reset = 1'b0;
      #1;
      check("t6_miso_oe_reset", {17'b0, spi_miso_oe}, 18'h000);
      check("t6_miso_reset", {17'b0, spi_miso}, 18'h000);
      cpu_rd(2'd1, d); check("t6_status_reset", d, 18'h000);
      cpu_rd(2'd2, d); check("t6_ctrl_reset", d, 18'h000);
      cpu_rd(2'd0, d); check("t6_data_reset", d, 18'h000);
      spi_cs_n = 1'b1;
      spi_sclk = 1'b0;
      repeat (2) @(negedge clk_peri);
      reset = 1'b1;
      repeat (4) @(negedge clk_peri);
      cpu_rd(2'd1, d); check("t6_status_after_release", d, 18'h000);

`ifdef SPI_SLAVE_IRQ_EN
      // Interrupt on received byte
      cpu_wr(2'd2, 8'h03);
      cpu_rd(2'd2, d); check("t7_ctrl_irq_en", d, 18'h003);
      spi_cs_n = 1'b0;
      for (int i = 7; i >= 1; i--) spi_bit(1'(8'h42 >> i), r);
      spi_mosi = 1'b0;
      repeat (8) @(negedge clk_peri);
      spi_sclk = 1'b1;
      check("t7_irq_before", {17'b0, irq}, 18'h000);
      repeat (5) @(negedge clk_peri);
      check("t7_irq_set", {17'b0, irq}, 18'h001);
      repeat (3) @(negedge clk_peri);
      spi_sclk = 1'b0;
      cs_end();
      cpu_rd(2'd0, d); check("t7_data", d, 18'h042);
      @(negedge clk_peri);
      #1 check("t7_irq_cleared", {17'b0, irq}, 18'h000);
`else
      cpu_wr(2'd2, 8'h03);
      cpu_rd(2'd2, d); check("t7_ctrl_no_irq_bit", d, 18'h001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
